cp_dma_block_engine: RTL

//  Parametrised coprocessor DMA wrapper: CPU-programmed block mover feeding a generic block engine (AES etc.).

---
 rtl/cp_dma_block_engine.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cp_dma_block_engine.sv
// Coprocessor DMA wrapper: reads LEN words from SRC, runs them through a block engine in chunks, writes to DST.
// Optional feature macro: CP_DMA_CYCLE_COUNT_EN adds a saturating busy-cycle counter at register 4.
module cp_dma_block_engine #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned BUF_BLOCKS  = 16,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned ADDR_STEP   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       we_cpu,
    input  logic [2:0]                 addr_cpu,
    input  logic [31:0]                wrData_cpu,
    output logic [31:0]                rdData_cpu,
    output logic                       HOLD,
    input  logic                       HOLD_ACK,
    output logic                       we_dma,
    output logic [31:0]                addr_dma,
    input  logic [31:0]                dma_rd_data,
    output logic [31:0]                dma_wr_data,
    output logic                       eng_start,
    output logic [32*BLOCK_WORDS-1:0]  eng_block,
    output logic [31:0]                eng_mode,
    input  logic                       eng_done,
    input  logic [32*BLOCK_WORDS-1:0]  eng_result,
    output logic                       INT
);

    localparam int unsigned BUF_WORDS = BUF_BLOCKS * BLOCK_WORDS;
    localparam int unsigned CNT_W     = $clog2(BUF_WORDS + 1);
    localparam int unsigned BLK_AW    = $clog2(BUF_BLOCKS);
    localparam int unsigned ENG_W     = 32 * BLOCK_WORDS;
    localparam int unsigned ENG_AW    = $clog2(ENG_W);

    typedef enum logic [2:0] {
        S_IDLE, S_RREQ, S_RD, S_PAD, S_PROC, S_WREQ, S_WR, S_NEXT
    } state_t;

    state_t             r_state, w_next;
    logic               r_int, r_go, r_busy, r_err, r_int_en;
    logic [LEN_W-1:0]   r_len, r_rem;
    logic [31:0]        r_src, r_dst, r_mode;
    logic [31:0]        r_src_ptr, r_dst_ptr, r_addr;
    logic [CNT_W-1:0]   r_chunk, r_nwords, r_cnt;
    logic [BLK_AW-1:0]  r_blk;
    logic               r_wait, r_eng_start;
    logic [ENG_W-1:0]   r_eng_block;
    logic [ENG_W-1:0]   r_buf [BUF_BLOCKS];

    logic               w_wr_ctrl, w_len_zero, w_go_req, w_go_ok, w_go_zero, w_done;
    logic               w_hold, w_we;
    logic [CNT_W-1:0]   w_chunk, w_nwords;
    logic [BLK_AW-1:0]  w_wblk, w_last_blk;
    logic [ENG_AW-1:0]  w_wsel;
    logic [31:0]        w_chunk_bytes, w_cycles;

    // CPU register decode
    assign w_wr_ctrl  = we_cpu && (addr_cpu == 3'd0);
    assign w_len_zero = (wrData_cpu[LEN_W-1:0] == '0);
    assign w_go_req   = w_wr_ctrl && wrData_cpu[30] && !r_busy;
    assign w_go_ok    = w_go_req && !w_len_zero;
    assign w_go_zero  = w_go_req && w_len_zero;
    assign w_done     = (r_state == S_NEXT) && (r_rem == LEN_W'(r_chunk));

    // Chunk sizing and buffer word addressing
    assign w_chunk       = (r_rem > LEN_W'(BUF_WORDS)) ? CNT_W'(BUF_WORDS) : CNT_W'(r_rem);
    assign w_nwords      = CNT_W'(((32'(w_chunk) + 32'(BLOCK_WORDS) - 32'd1) / 32'(BLOCK_WORDS))
                                  * 32'(BLOCK_WORDS));
    assign w_last_blk    = BLK_AW'((r_nwords / CNT_W'(BLOCK_WORDS)) - CNT_W'(1));
    assign w_wblk        = BLK_AW'(r_cnt / CNT_W'(BLOCK_WORDS));
    assign w_wsel        = ENG_AW'(32'd32 * 32'(r_cnt % CNT_W'(BLOCK_WORDS)));
    assign w_chunk_bytes = 32'(r_chunk) * 32'(ADDR_STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_int    <= 1'b0;
            r_go     <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_int_en <= 1'b0;
            r_len    <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_mode   <= '0;
        end else begin
            r_go <= w_go_ok;
            // hardware set of int beats a simultaneous W1C
            if (w_done || w_go_zero) begin
                r_int <= 1'b1;
            end else if (w_wr_ctrl && wrData_cpu[31]) begin
                r_int <= 1'b0;
            end
            if (w_go_ok) begin
                r_busy <= 1'b1;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end
            if (w_go_zero) begin
                r_err <= 1'b1;
            end else if (w_go_ok) begin
                r_err <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_int_en <= wrData_cpu[27];
            end
            if (we_cpu && !r_busy) begin
                case (addr_cpu)
                    3'd0:    r_len  <= wrData_cpu[LEN_W-1:0];
                    3'd1:    r_src  <= wrData_cpu;
                    3'd2:    r_dst  <= wrData_cpu;
                    3'd3:    r_mode <= wrData_cpu;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_hold = 1'b0;
        w_we   = 1'b0;
        case (r_state)
            S_IDLE: if (r_go) w_next = S_RREQ;
            S_RREQ: begin
                w_hold = 1'b1;
                w_next = S_RD;
            end
            S_RD: begin
                w_hold = 1'b1;
                if (HOLD_ACK && (r_cnt == r_chunk - CNT_W'(1))) w_next = S_PAD;
            end
            S_PAD:  if (r_cnt == r_nwords) w_next = S_PROC;
            S_PROC: if (r_wait && eng_done && (r_blk == w_last_blk)) w_next = S_WREQ;
            S_WREQ: begin
                w_hold = 1'b1;
                w_next = S_WR;
            end
            S_WR: begin
                w_hold = 1'b1;
                w_we   = HOLD_ACK;
                if (HOLD_ACK && (r_cnt == r_nwords - CNT_W'(1))) w_next = S_NEXT;
            end
            S_NEXT:  w_next = w_done ? S_IDLE : S_RREQ;
            default: w_next = S_IDLE;
        endcase
    end

    // Transfer datapath: pointers, counters, engine handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_chunk     <= '0;
            r_nwords    <= '0;
            r_cnt       <= '0;
            r_blk       <= '0;
            r_wait      <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_block <= '0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                S_IDLE: if (r_go) begin
                    r_src_ptr <= r_src;
                    r_dst_ptr <= r_dst;
                    r_rem     <= r_len;
                end
                S_RREQ: begin
                    r_addr   <= r_src_ptr;
                    r_chunk  <= w_chunk;
                    r_nwords <= w_nwords;
                    r_cnt    <= '0;
                    r_blk    <= '0;
                    r_wait   <= 1'b0;
                end
                S_RD, S_WR: if (HOLD_ACK) begin
                    r_addr <= r_addr + 32'(ADDR_STEP);
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                S_PAD: if (r_cnt != r_nwords) r_cnt <= r_cnt + CNT_W'(1);
                S_PROC: begin
                    if (!r_wait) begin
                        r_eng_start <= 1'b1;
                        r_eng_block <= r_buf[r_blk];
                        r_wait      <= 1'b1;
                    end else if (eng_done) begin
                        r_wait <= 1'b0;
                        r_blk  <= r_blk + BLK_AW'(1);
                    end
                end
                S_WREQ: begin
                    r_addr <= r_dst_ptr;
                    r_cnt  <= '0;
                end
                S_NEXT: begin
                    r_rem     <= r_rem - LEN_W'(r_chunk);
                    r_src_ptr <= r_src_ptr + w_chunk_bytes;
                    r_dst_ptr <= r_dst_ptr + w_chunk_bytes;
                end
                default: ;
            endcase
        end
    end

    // Block buffer has no reset: contents are don't-care until filled by a read phase
    always_ff @(posedge clk) begin
        if ((r_state == S_RD) && HOLD_ACK) begin
            r_buf[w_wblk][w_wsel +: 32] <= dma_rd_data;
        end else if ((r_state == S_PAD) && (r_cnt != r_nwords)) begin
            r_buf[w_wblk][w_wsel +: 32] <= '0;
        end else if ((r_state == S_PROC) && r_wait && eng_done) begin
            r_buf[r_blk] <= eng_result;
        end
    end

`ifdef CP_DMA_CYCLE_COUNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (w_go_ok) begin
            r_cycles <= '0;
        end else if (r_busy && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    always_comb begin
        rdData_cpu = '0;
        case (addr_cpu)
            3'd0:    rdData_cpu = {r_int, r_go, r_busy, r_err, r_int_en, {(27-LEN_W){1'b0}}, r_len};
            3'd1:    rdData_cpu = r_src;
            3'd2:    rdData_cpu = r_dst;
            3'd3:    rdData_cpu = r_mode;
            3'd4:    rdData_cpu = w_cycles;
            default: rdData_cpu = '0;
        endcase
    end

    assign HOLD        = w_hold;
    assign we_dma      = w_we;
    assign addr_dma    = r_addr;
    assign dma_wr_data = (r_state == S_WR) ? r_buf[w_wblk][w_wsel +: 32] : 32'h0;
    assign eng_start   = r_eng_start;
    assign eng_block   = r_eng_block;
    assign eng_mode    = r_mode;
    assign INT         = r_int & r_int_en;

endmodule
